// File: rtl/address_serializer.sv
// Master-side address serializer: arbitrates for the bus, shifts the slave
// address LSB-first, then waits for the slave acknowledge with timeout and retry.
module address_serializer #(
  parameter int ADDR_WIDTH  = 2,
  parameter int ACK_TIMEOUT = 8,
  parameter int MAX_RETRY   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  M_REQ,
  input  logic [ADDR_WIDTH-1:0] M_ADDR,
  output logic                  M_READY,
  output logic                  M_DONE,
  output logic                  M_ERR,
  output logic                  B_REQ,
  input  logic                  B_GRANT,
  output logic                  B_UTIL,
  output logic                  A_ADD,
  output logic                  B_BUS_IN,
  input  logic                  S_ACK
);

  localparam int              BCW       = $clog2(ADDR_WIDTH + 1);
  localparam logic [BCW-1:0]  LAST_BIT  = BCW'(ADDR_WIDTH - 1);
  localparam logic [BCW-1:0]  BCNT_ONE  = BCW'(1);
  localparam logic [7:0]      ACK_TO    = 8'(ACK_TIMEOUT);
  localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_ADDR     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s, addr_shift_s;
  logic [BCW-1:0]        bcnt_r, bcnt_s;
  logic [7:0]            tcnt_r, tcnt_s, tcnt_inc_s;
  logic [2:0]            rcnt_r, rcnt_s;

  logic m_ready_r, m_done_r, m_err_r, b_req_r, b_util_r, a_add_r, b_bus_in_r;
  logic m_ready_s, m_done_s, m_err_s, b_req_s, b_util_s, a_add_s, b_bus_in_s;

  // Next-state, counter updates and next output values (outputs follow the next state).
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    bcnt_s       = bcnt_r;
    tcnt_s       = tcnt_r;
    rcnt_s       = rcnt_r;
    tcnt_inc_s   = tcnt_r + 8'd1;
    addr_shift_s = {ADDR_WIDTH{1'b0}};
    m_ready_s    = 1'b0;
    m_done_s     = 1'b0;
    m_err_s      = 1'b0;
    b_req_s      = 1'b0;
    b_util_s     = 1'b0;
    a_add_s      = 1'b0;
    b_bus_in_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (M_REQ) begin
          addr_s = M_ADDR;
          bcnt_s = {BCW{1'b0}};
          tcnt_s = 8'd0;
          rcnt_s = 3'd0;
          if (M_ADDR == {ADDR_WIDTH{1'b0}}) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_ARB;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (B_GRANT) begin
          state_s = ST_ADDR;
          bcnt_s  = {BCW{1'b0}};
        end else begin
          state_s = ST_ARB;
        end
      end
      ST_ADDR: begin
        // Losing the grant restarts the whole address after re-arbitration.
        if (!B_GRANT) begin
          state_s = ST_ARB;
          bcnt_s  = {BCW{1'b0}};
          tcnt_s  = 8'd0;
        end else if (bcnt_r == LAST_BIT) begin
          state_s = ST_WAIT_ACK;
          tcnt_s  = 8'd0;
        end else begin
          bcnt_s  = bcnt_r + BCNT_ONE;
        end
      end
      ST_WAIT_ACK: begin
        if (!B_GRANT) begin
          state_s = ST_ARB;
          bcnt_s  = {BCW{1'b0}};
          tcnt_s  = 8'd0;
        end else if (S_ACK) begin
          state_s = ST_DONE;
        end else if (tcnt_inc_s == ACK_TO) begin
          if (rcnt_r < RETRY_MAX) begin
            state_s = ST_ADDR;
            rcnt_s  = rcnt_r + 3'd1;
            bcnt_s  = {BCW{1'b0}};
            tcnt_s  = 8'd0;
          end else begin
            state_s = ST_ERR;
          end
        end else begin
          tcnt_s = tcnt_inc_s;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    addr_shift_s = addr_s >> bcnt_s;
    m_ready_s    = (state_s == ST_IDLE);
    m_done_s     = (state_s == ST_DONE);
    m_err_s      = (state_s == ST_ERR);
    b_req_s      = (state_s == ST_ARB) || (state_s == ST_ADDR) || (state_s == ST_WAIT_ACK);
    b_util_s     = (state_s == ST_ADDR) || (state_s == ST_WAIT_ACK);
    a_add_s      = (state_s == ST_ADDR);
    b_bus_in_s   = (state_s == ST_ADDR) && addr_shift_s[0];
  end

  // State, counters, captured address and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      bcnt_r     <= {BCW{1'b0}};
      tcnt_r     <= 8'd0;
      rcnt_r     <= 3'd0;
      m_ready_r  <= 1'b1;
      m_done_r   <= 1'b0;
      m_err_r    <= 1'b0;
      b_req_r    <= 1'b0;
      b_util_r   <= 1'b0;
      a_add_r    <= 1'b0;
      b_bus_in_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      bcnt_r     <= bcnt_s;
      tcnt_r     <= tcnt_s;
      rcnt_r     <= rcnt_s;
      m_ready_r  <= m_ready_s;
      m_done_r   <= m_done_s;
      m_err_r    <= m_err_s;
      b_req_r    <= b_req_s;
      b_util_r   <= b_util_s;
      a_add_r    <= a_add_s;
      b_bus_in_r <= b_bus_in_s;
    end
  end

  assign M_READY  = m_ready_r;
  assign M_DONE   = m_done_r;
  assign M_ERR    = m_err_r;
  assign B_REQ    = b_req_r;
  assign B_UTIL   = b_util_r;
  assign A_ADD    = a_add_r;
  assign B_BUS_IN = b_bus_in_r;

endmodule

// File: tb/tb_address_serializer.sv
// Bench for address_serializer: transaction scenarios are expanded into an
// expected per-cycle output trace and replayed against the DUT.
module tb_address_serializer;

  localparam int AW = 2;
  localparam int T  = 8;
  localparam int MR = 2;

  // {M_READY, M_DONE, M_ERR, B_REQ, B_UTIL, A_ADD, B_BUS_IN}
  localparam logic [6:0] O_IDLE = 7'b1000000;
  localparam logic [6:0] O_DONE = 7'b0100000;
  localparam logic [6:0] O_ERR  = 7'b0010000;
  localparam logic [6:0] O_ARB  = 7'b0001000;
  localparam logic [6:0] O_WAIT = 7'b0001100;

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic          grant;
    logic          ack;
    logic [6:0]    exp;
  } cyc_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          M_REQ = 1'b0;
  logic [AW-1:0] M_ADDR = '0;
  logic          B_GRANT = 1'b0;
  logic          S_ACK = 1'b0;
  logic M_READY, M_DONE, M_ERR, B_REQ, B_UTIL, A_ADD, B_BUS_IN;

  cyc_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;
  int   bursts  = 0;
  int   dec_cnt = 0;
  bit   dec_active = 1'b0;
  logic [7:0] dec_shift = 8'd0;
  logic [7:0] last_sel = 8'd0;

  address_serializer #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(T), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RST(RST), .M_REQ(M_REQ), .M_ADDR(M_ADDR), .M_READY(M_READY),
    .M_DONE(M_DONE), .M_ERR(M_ERR), .B_REQ(B_REQ), .B_GRANT(B_GRANT),
    .B_UTIL(B_UTIL), .A_ADD(A_ADD), .B_BUS_IN(B_BUS_IN), .S_ACK(S_ACK)
  );

  always #5 CLK = ~CLK;

  wire [6:0] obs = {M_READY, M_DONE, M_ERR, B_REQ, B_UTIL, A_ADD, B_BUS_IN};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom);
  endfunction

  function automatic logic [6:0] o_addr(input logic [AW-1:0] a, input int k);
    logic [AW-1:0] s;
    s = a >> k;
    return {6'b000111, s[0]};
  endfunction

  task automatic push(input logic req, input logic [AW-1:0] a, input logic g,
                      input logic k, input logic [6:0] e);
    cyc_t c;
    c.req = req; c.addr = a; c.grant = g; c.ack = k; c.exp = e;
    q.push_back(c);
  endtask

  // Expand one transaction into stimulus/expected cycles. ack_try/drop_try
  // select the transmission attempt (-1 = never); drop_pos < AW drops the grant
  // while bit drop_pos is on the line, otherwise in wait cycle drop_pos-AW.
  task automatic build_txn(input logic [AW-1:0] a, input int gd_first, input int ack_try,
                           input int ack_pos, input int drop_try, input int drop_pos);
    int tries;
    int gd;
    bit dropped;
    bit fin;
    bit need_arb;
    push(1'b1, a, rbit(), rbit(), (a == '0) ? O_ERR : O_ARB);
    fin = (a == '0);
    tries = 0; dropped = 1'b0; need_arb = 1'b1;
    gd = (gd_first < 0) ? int'($urandom_range(0, 3)) : gd_first;
    while (!fin) begin
      if (need_arb) begin
        repeat (gd) push(rbit(), raddr(), 1'b0, rbit(), O_ARB);
        push(rbit(), raddr(), 1'b1, rbit(), o_addr(a, 0));
        need_arb = 1'b0;
        gd = $urandom_range(0, 3);
      end
      for (int k = 0; k < AW && !need_arb; k++) begin
        if (!dropped && tries == drop_try && drop_pos == k) begin
          push(rbit(), raddr(), 1'b0, rbit(), O_ARB);
          dropped = 1'b1; need_arb = 1'b1;
        end else begin
          push(rbit(), raddr(), 1'b1, rbit(), (k == AW - 1) ? O_WAIT : o_addr(a, k + 1));
        end
      end
      for (int j = 0; j < T && !need_arb && !fin; j++) begin
        if (!dropped && tries == drop_try && drop_pos == AW + j) begin
          push(rbit(), raddr(), 1'b0, 1'b0, O_ARB);
          dropped = 1'b1; need_arb = 1'b1;
        end else if (tries == ack_try && j == ack_pos) begin
          push(rbit(), raddr(), 1'b1, 1'b1, O_DONE);
          fin = 1'b1;
        end else if (j == T - 1) begin
          if (tries < MR) begin
            tries++;
            push(rbit(), raddr(), 1'b1, 1'b0, o_addr(a, 0));
          end else begin
            push(rbit(), raddr(), 1'b1, 1'b0, O_ERR);
            fin = 1'b1;
          end
        end else begin
          push(rbit(), raddr(), 1'b1, 1'b0, O_WAIT);
        end
      end
    end
    push(rbit(), raddr(), rbit(), rbit(), O_IDLE);
  endtask

  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge CLK);
      M_REQ = c.req; M_ADDR = c.addr; B_GRANT = c.grant; S_ACK = c.ack;
      @(posedge CLK);
      #1;
      check_eq($sformatf("cyc%0d", cyc_n), {25'd0, obs}, {25'd0, c.exp});
      // Slave-side decoder: collects bits while A_ADD is high, selects on its fall.
      if (A_ADD) begin
        if (!dec_active) begin
          dec_shift = 8'd0; dec_cnt = 0; bursts++;
        end
        if (dec_cnt < 8) dec_shift[dec_cnt] = B_BUS_IN;
        dec_cnt++;
        dec_active = 1'b1;
      end else begin
        if (dec_active && dec_cnt == AW) last_sel = dec_shift;
        dec_active = 1'b0;
      end
      cyc_n++;
    end
  endtask

  initial begin
    #2 RST = 1'b1;
    #1 check_eq("reset_outs", {25'd0, obs}, {25'd0, O_IDLE});
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    bursts = 0; last_sel = 8'd0;
    build_txn(2'd2, 1, 0, 2, -1, 0);
    run_queue();
    check_eq("basic_sel", last_sel, 32'd2);
    check_eq("basic_bursts", bursts, 32'd1);

    build_txn(2'd0, 0, -1, 0, -1, 0);
    run_queue();

    bursts = 0;
    build_txn(2'd1, 0, -1, 0, -1, 0);
    run_queue();
    check_eq("timeout_bursts", bursts, 32'd3);

    bursts = 0;
    build_txn(2'd3, 2, 1, 4, -1, 0);
    run_queue();
    check_eq("retry_ack_bursts", bursts, 32'd2);

    bursts = 0; last_sel = 8'd0;
    build_txn(2'd3, 0, 0, 1, 0, 0);
    run_queue();
    check_eq("drop_bursts", bursts, 32'd2);
    check_eq("drop_sel", last_sel, 32'd3);

    bursts = 0;
    build_txn(2'd2, 0, MR, T - 1, -1, 0);
    run_queue();
    check_eq("late_ack_bursts", bursts, 32'd3);

    build_txn(2'd1, 1, 1, 3, 0, AW + 5);
    run_queue();

    // Asynchronous reset while bit 0 is on the line.
    push(1'b1, 2'd3, 1'b0, 1'b0, O_ARB);
    push(1'b0, 2'd3, 1'b1, 1'b0, o_addr(2'd3, 0));
    run_queue();
    #2 RST = 1'b1;
    #1 check_eq("rst_mid_addr", {25'd0, obs}, {25'd0, O_IDLE});
    M_REQ = 1'b0; B_GRANT = 1'b0; S_ACK = 1'b0;
    dec_active = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    last_sel = 8'd0;
    build_txn(2'd3, 0, 0, 0, -1, 0);
    run_queue();
    check_eq("post_rst_sel", last_sel, 32'd3);

    repeat (40) begin
      repeat ($urandom_range(0, 2)) push(1'b0, raddr(), rbit(), rbit(), O_IDLE);
      build_txn(raddr(), -1,
                int'($urandom_range(0, 3)), int'($urandom_range(0, T - 1)),
                ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, MR)),
                int'($urandom_range(0, AW + T - 1)));
    end
    run_queue();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
